// File: rtl/id_ex_stage_pkg.sv
// ============================================================================
// Module  : id_ex_stage_pkg
// Brief   : Shared types for the ID/EX stage: decode bundle, branch codes, WFI FSM.
// Revision: 1.0
// ============================================================================
`default_nettype none

package id_ex_stage_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LT   = 3'd3,
    BR_GE   = 3'd4,
    BR_LTU  = 3'd5,
    BR_GEU  = 3'd6,
    BR_JUMP = 3'd7
  } br_ctrl_e;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    SLEEP = 1'b1
  } wfi_st_e;

  typedef struct packed {
    logic [31:0]           pc;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [31:0]           rs1_data;
    logic [31:0]           rs2_data;
    logic [31:0]           imm;
    logic [3:0]            alu_op;
    logic [11:0]           csr_addr;
    br_ctrl_e              branch_ctrl;
    logic                  reg_wr;
    logic                  dm_rd;
    logic                  dm_wr;
    logic                  dm2reg;
    logic                  csr;
    logic                  csr_wr;
    logic                  csr_set;
    logic                  csr_clr;
    logic                  csr_mret;
    logic                  csr_wfi;
  } id_ex_bus_t;

  // A bubble has every side-effect control cleared; data fields are driven 0 too.
  function automatic id_ex_bus_t bubble_bus();
    id_ex_bus_t b;
    b             = '0;
    b.branch_ctrl = BR_NONE;
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_if.sv
// ============================================================================
// Module  : inf_ID_EX
// Brief   : Decode bundle carried from ID into EX.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface inf_ID_EX;
  import id_ex_stage_pkg::*;

  id_ex_bus_t bus;

  modport ID2EX  (output bus);
  modport EX2ID  (input  bus);
  modport master (output bus);
  modport slave  (input  bus);
endinterface

`default_nettype wire

// File: rtl/id_ex_stage_hazard.sv
// ============================================================================
// Module  : id_ex_hazard
// Brief   : Combinational load-use and CSR-serialization hazard detection.
// Revision: 1.0
// ============================================================================
`default_nettype none

module id_ex_hazard
  import id_ex_stage_pkg::*;
#(
  parameter bit CSR_SERIAL = 1'b1
) (
  input  wire logic                  ex_valid,
  input  wire logic                  ex_dm_rd,
  input  wire logic                  ex_csr,
  input  wire logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  wire logic                  id_valid,
  input  wire logic                  id_csr,
  input  wire logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  wire logic [REG_ADDR_W-1:0] id_rs2_addr,
  output      logic                  lu_haz,
  output      logic                  csr_haz
);

  logic w_rd_nz;
  logic w_src_match;

  // rs2 is compared for every format: a spurious stall is harmless, a missed one is not.
  assign w_rd_nz     = (ex_rd_addr != '0);
  assign w_src_match = (ex_rd_addr == id_rs1_addr) | (ex_rd_addr == id_rs2_addr);
  assign lu_haz      = ex_valid & ex_dm_rd & w_rd_nz & w_src_match & id_valid;

  generate
    if (CSR_SERIAL) begin : g_csr_serial
      assign csr_haz = ex_valid & ex_csr & id_valid & id_csr;
    end else begin : g_csr_free
      assign csr_haz = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module  : id_ex_stage
// Brief   : ID/EX pipeline register with bubble insertion, WFI sleep FSM and stall counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int STALL_CNT_W = 32,
  parameter bit CSR_SERIAL  = 1'b1
) (
  input  wire logic                   clk,
  input  wire logic                   rstn,
  inf_ID_EX.EX2ID                     id_in,
  input  wire logic                   id_valid,
  inf_ID_EX.ID2EX                     ex_out,
  output      logic                   ex_valid,
  input  wire logic                   ex_stall,
  input  wire logic                   br_flush,
  input  wire logic                   irq_pending,
  output      logic                   id_hold,
  output      logic                   wfi_sleep,
  output      logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  id_ex_bus_t r_ex_bus;
  wfi_st_e    r_st;

  logic w_lu_haz;
  logic w_csr_haz;
  logic w_sleep;
  logic w_bubble;
  logic w_wfi_enter;

  id_ex_hazard #(
    .CSR_SERIAL (CSR_SERIAL)
  ) u_hazard (
    .ex_valid    (ex_valid),
    .ex_dm_rd    (r_ex_bus.dm_rd),
    .ex_csr      (r_ex_bus.csr),
    .ex_rd_addr  (r_ex_bus.rd_addr),
    .id_valid    (id_valid),
    .id_csr      (id_in.bus.csr),
    .id_rs1_addr (id_in.bus.rs1_addr),
    .id_rs2_addr (id_in.bus.rs2_addr),
    .lu_haz      (w_lu_haz),
    .csr_haz     (w_csr_haz)
  );

  assign w_sleep     = (r_st == SLEEP);
  // A flush redirects IF, so it must not also freeze the PC.
  assign w_bubble    = br_flush | w_sleep | w_lu_haz | w_csr_haz;
  assign id_hold     = ex_stall | (~br_flush & (w_sleep | w_lu_haz | w_csr_haz));
  assign wfi_sleep   = w_sleep;
  assign w_wfi_enter = ex_valid & r_ex_bus.csr_wfi & ~ex_stall & ~br_flush & ~irq_pending;
  assign ex_out.bus  = r_ex_bus;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ex_bus  <= bubble_bus();
      ex_valid  <= 1'b0;
      r_st      <= RUN;
      stall_cnt <= '0;
    end else begin
      if (!ex_stall) begin
        if (w_bubble) begin
          r_ex_bus <= bubble_bus();
          ex_valid <= 1'b0;
        end else begin
          r_ex_bus <= id_in.bus;
          ex_valid <= id_valid;
        end
      end

      case (r_st)
        RUN:     if (w_wfi_enter) r_st <= SLEEP;
        SLEEP:   if (irq_pending) r_st <= RUN;
        default: r_st <= RUN;
      endcase

      if (id_hold && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
    end
  end

  // EX cannot both stall and resolve a taken branch in the same cycle.
  a_no_stall_flush : assert property (@(posedge clk) disable iff (!rstn) !(ex_stall && br_flush));

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module  : tb_id_ex_stage
// Brief   : Self-checking bench for id_ex_stage (cycle vector table + scoreboard).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  typedef enum int {K_NOP, K_LW, K_ADD, K_SW, K_CSRRW, K_CSRRS, K_WFI} kind_e;

  typedef struct {
    id_ex_bus_t  id;
    logic        id_valid;
    logic        stall;
    logic        flush;
    logic        irq;
    logic        exp_hold;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_sleep;
    int          exp_cnt;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        sleep;
    int          cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        id_valid = 1'b0;
  logic        ex_valid, ex_valid_s;
  logic        ex_stall = 1'b0;
  logic        br_flush = 1'b0;
  logic        irq_pending = 1'b0;
  logic        id_hold, id_hold_s;
  logic        wfi_sleep, wfi_sleep_s;
  logic [31:0] stall_cnt;
  logic [1:0]  stall_cnt_s;

  int tests  = 0;
  int failed = 0;

  vec_t vq[$];
  exp_t sb[$];

  inf_ID_EX id_if ();
  inf_ID_EX ex_if ();
  inf_ID_EX ex_if_s ();

  id_ex_stage #(.STALL_CNT_W(32), .CSR_SERIAL(1'b1)) dut (
    .clk(clk), .rstn(rstn), .id_in(id_if), .id_valid(id_valid), .ex_out(ex_if),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .br_flush(br_flush),
    .irq_pending(irq_pending), .id_hold(id_hold), .wfi_sleep(wfi_sleep),
    .stall_cnt(stall_cnt)
  );

  // Narrow counter instance shares all inputs so saturation is reached quickly.
  id_ex_stage #(.STALL_CNT_W(2), .CSR_SERIAL(1'b1)) dut_sat (
    .clk(clk), .rstn(rstn), .id_in(id_if), .id_valid(id_valid), .ex_out(ex_if_s),
    .ex_valid(ex_valid_s), .ex_stall(ex_stall), .br_flush(br_flush),
    .irq_pending(irq_pending), .id_hold(id_hold_s), .wfi_sleep(wfi_sleep_s),
    .stall_cnt(stall_cnt_s)
  );

  always #5 clk = ~clk;

  function automatic id_ex_bus_t mk(input kind_e k, input logic [31:0] pc,
                                    input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2);
    id_ex_bus_t b;
    b             = '0;
    b.branch_ctrl = BR_NONE;
    if (k == K_NOP) return b;
    b.pc       = pc;
    b.rs1_addr = rs1;
    b.rs2_addr = rs2;
    b.rs1_data = pc ^ 32'h0000_A5A5;
    b.rs2_data = pc ^ 32'h5A5A_0000;
    b.imm      = pc + 32'd4;
    case (k)
      K_LW:    begin b.rd_addr = rd; b.reg_wr = 1'b1; b.dm_rd = 1'b1; b.dm2reg = 1'b1; end
      K_ADD:   begin b.rd_addr = rd; b.reg_wr = 1'b1; b.alu_op = 4'd1; end
      K_SW:    begin b.dm_wr = 1'b1; end
      K_CSRRW: begin b.rd_addr = rd; b.reg_wr = 1'b1; b.csr = 1'b1; b.csr_wr = 1'b1; b.csr_addr = 12'h300; end
      K_CSRRS: begin b.rd_addr = rd; b.reg_wr = 1'b1; b.csr = 1'b1; b.csr_set = 1'b1; b.csr_addr = 12'h344; end
      K_WFI:   begin b.csr_wfi = 1'b1; end
      default: ;
    endcase
    return b;
  endfunction

  task automatic add(input id_ex_bus_t id, input logic idv, input logic st, input logic fl,
                     input logic irq, input logic hold, input logic ev, input logic [31:0] epc,
                     input logic esl, input int ecnt);
    vq.push_back('{id, idv, st, fl, irq, hold, ev, epc, esl, ecnt});
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    id_if.bus   = v.id;
    id_valid    = v.id_valid;
    ex_stall    = v.stall;
    br_flush    = v.flush;
    irq_pending = v.irq;
    @(negedge clk);
    chk("id_hold", idx, {31'd0, id_hold}, {31'd0, v.exp_hold});
    sb.push_back('{v.exp_valid, v.exp_pc, v.exp_sleep, v.exp_cnt});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("ex_valid", idx, {31'd0, ex_valid}, {31'd0, e.valid});
    chk("ex_pc", idx, ex_if.bus.pc, e.pc);
    chk("wfi_sleep", idx, {31'd0, wfi_sleep}, {31'd0, e.sleep});
    chk("stall_cnt", idx, stall_cnt, e.cnt);
    chk("stall_cnt_sat", idx, {30'd0, stall_cnt_s}, (e.cnt > 3) ? 32'd3 : e.cnt);
    if (!e.valid && e.pc == 32'd0) begin
      chk("bubble_ctl", idx,
          {19'd0, ex_if.bus.reg_wr, ex_if.bus.dm_rd, ex_if.bus.dm_wr, ex_if.bus.dm2reg,
           ex_if.bus.csr, ex_if.bus.csr_wr, ex_if.bus.csr_set, ex_if.bus.csr_clr,
           ex_if.bus.csr_mret, ex_if.bus.csr_wfi, ex_if.bus.branch_ctrl}, 32'd0);
    end
  endtask

  initial begin
    id_if.bus = mk(K_NOP, 0, 0, 0, 0);

    // load-use on rs1, then x0 destination (no stall)
    add(mk(K_LW,   'h10,  5, 2, 0), 1, 0, 0, 0,  0, 1, 'h10, 0, 0);
    add(mk(K_ADD,  'h14,  6, 5, 1), 1, 0, 0, 0,  1, 0, 0,    0, 1);
    add(mk(K_ADD,  'h14,  6, 5, 1), 1, 0, 0, 0,  0, 1, 'h14, 0, 1);
    add(mk(K_LW,   'h18,  0, 2, 0), 1, 0, 0, 0,  0, 1, 'h18, 0, 1);
    add(mk(K_ADD,  'h1c,  6, 0, 1), 1, 0, 0, 0,  0, 1, 'h1c, 0, 1);
    // load-use on rs2, then load-use masked by a branch flush
    add(mk(K_LW,   'h20,  7, 1, 0), 1, 0, 0, 0,  0, 1, 'h20, 0, 1);
    add(mk(K_SW,   'h24,  0, 2, 7), 1, 0, 0, 0,  1, 0, 0,    0, 2);
    add(mk(K_SW,   'h24,  0, 2, 7), 1, 0, 0, 0,  0, 1, 'h24, 0, 2);
    add(mk(K_LW,   'h28,  7, 1, 0), 1, 0, 0, 0,  0, 1, 'h28, 0, 2);
    add(mk(K_ADD,  'h2c,  8, 7, 7), 1, 0, 1, 0,  0, 0, 0,    0, 2);
    // three-cycle EX stall holds the add in EX
    add(mk(K_ADD,  'h30,  9, 1, 2), 1, 0, 0, 0,  0, 1, 'h30, 0, 2);
    add(mk(K_ADD,  'h34, 10, 1, 2), 1, 1, 0, 0,  1, 1, 'h30, 0, 3);
    add(mk(K_ADD,  'h34, 10, 1, 2), 1, 1, 0, 0,  1, 1, 'h30, 0, 4);
    add(mk(K_ADD,  'h34, 10, 1, 2), 1, 1, 0, 0,  1, 1, 'h30, 0, 5);
    add(mk(K_ADD,  'h34, 10, 1, 2), 1, 0, 0, 0,  0, 1, 'h34, 0, 5);
    // WFI sleeps until irq_pending, then wakes
    add(mk(K_WFI,  'h38,  0, 0, 0), 1, 0, 0, 0,  0, 1, 'h38, 0, 5);
    add(mk(K_ADD,  'h3c, 11, 1, 2), 1, 0, 0, 0,  0, 1, 'h3c, 1, 5);
    add(mk(K_ADD,  'h40, 12, 1, 2), 1, 0, 0, 0,  1, 0, 0,    1, 6);
    add(mk(K_ADD,  'h40, 12, 1, 2), 1, 0, 0, 0,  1, 0, 0,    1, 7);
    add(mk(K_ADD,  'h40, 12, 1, 2), 1, 0, 0, 1,  1, 0, 0,    0, 8);
    add(mk(K_ADD,  'h40, 12, 1, 2), 1, 0, 0, 1,  0, 1, 'h40, 0, 8);
    // WFI with interrupt already pending retires without sleeping
    add(mk(K_WFI,  'h44,  0, 0, 0), 1, 0, 0, 1,  0, 1, 'h44, 0, 8);
    add(mk(K_ADD,  'h48, 13, 1, 2), 1, 0, 0, 1,  0, 1, 'h48, 0, 8);
    add(mk(K_ADD,  'h4c, 14, 1, 2), 1, 0, 0, 0,  0, 1, 'h4c, 0, 8);
    // CSR serialization, and no hazard when ID is not valid
    add(mk(K_CSRRW,'h50,  3, 4, 0), 1, 0, 0, 0,  0, 1, 'h50, 0, 8);
    add(mk(K_CSRRS,'h54,  5, 0, 0), 1, 0, 0, 0,  1, 0, 0,    0, 9);
    add(mk(K_CSRRS,'h54,  5, 0, 0), 1, 0, 0, 0,  0, 1, 'h54, 0, 9);
    add(mk(K_CSRRS,'h58,  5, 0, 0), 0, 0, 0, 0,  0, 0, 'h58, 0, 9);
    // enter sleep ahead of the mid-sleep reset
    add(mk(K_WFI,  'h5c,  0, 0, 0), 1, 0, 0, 0,  0, 1, 'h5c, 0, 9);
    add(mk(K_NOP,  0,     0, 0, 0), 0, 0, 0, 0,  0, 0, 0,    1, 9);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", 0, {31'd0, ex_valid}, 32'd0);
    chk("rst_id_hold", 0, {31'd0, id_hold}, 32'd0);
    chk("rst_wfi_sleep", 0, {31'd0, wfi_sleep}, 32'd0);
    chk("rst_stall_cnt", 0, stall_cnt, 32'd0);
    chk("rst_ex_pc", 0, ex_if.bus.pc, 32'd0);
    chk("rst_branch_ctrl", 0, {29'd0, ex_if.bus.branch_ctrl}, {29'd0, BR_NONE});
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vq.size(); i++) begin
      run_vec(vq[i], i + 1);
    end

    // asynchronous reset while asleep with a stall pending
    id_if.bus   = mk(K_ADD, 'h60, 15, 1, 2);
    id_valid    = 1'b1;
    irq_pending = 1'b0;
    #1;
    chk("pre_rst_id_hold", 100, {31'd0, id_hold}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_wfi_sleep", 101, {31'd0, wfi_sleep}, 32'd0);
    chk("async_rst_id_hold", 101, {31'd0, id_hold}, 32'd0);
    chk("async_rst_ex_valid", 101, {31'd0, ex_valid}, 32'd0);
    chk("async_rst_stall_cnt", 101, stall_cnt, 32'd0);
    chk("async_rst_stall_cnt_sat", 101, {30'd0, stall_cnt_s}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ex_valid", 102, {31'd0, ex_valid}, 32'd1);
    chk("post_rst_ex_pc", 102, ex_if.bus.pc, 32'h60);
    chk("post_rst_stall_cnt", 102, stall_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
